fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 49 ++++
 rtl/fetch_unit.sv | 116 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared widths, the fetch-queue entry payload and the pad instruction for the fetch unit.
package fetch_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;
    localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction queue with flush; push into a full queue is legal only alongside a pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign head    = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues sequential fetches, queues in-order responses for decode,
// and discards responses belonging to requests issued before a redirect.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [63:0] id_pc,
    input  logic        id_ready
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned DW = 16;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_n;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] resp_pc_n;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   outstanding_n;
    logic [DW-1:0]   drop_cnt;
    logic [DW-1:0]   drop_cnt_n;

    fetch_entry_t    fifo_head;
    fetch_entry_t    push_entry;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic            fifo_push;

    logic            deq;
    logic            grant;
    logic            rv_live;
    logic            rv_drop;
    logic [CW:0]     inflight;

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (deq),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            pc_q        <= pc_n;
            resp_pc     <= resp_pc_n;
            outstanding <= outstanding_n;
            drop_cnt    <= drop_cnt_n;
        end
    end

    always_comb begin
        pc_n             = pc_q;
        resp_pc_n        = resp_pc;
        outstanding_n    = outstanding;
        drop_cnt_n       = drop_cnt;
        push_entry.instr = imem_rdata;
        push_entry.pc    = resp_pc;

        id_valid = !rst && !redirect_valid && !fifo_empty;
        deq      = id_valid && id_ready;

        // Live requests plus queued entries must leave a slot, counting the one decode frees now.
        inflight = (CW+1)'(outstanding) + (CW+1)'(fifo_count);
        imem_req = !rst && !redirect_valid
                   && (inflight < (CW+1)'(FIFO_DEPTH) + (CW+1)'(deq))
                   && !(fifo_full && !deq);
        grant    = imem_req && imem_gnt;

        // Stale responses are always older than live ones, so they are consumed first.
        rv_drop   = imem_rvalid && (drop_cnt != '0);
        rv_live   = imem_rvalid && (drop_cnt == '0) && (outstanding != '0);
        fifo_push = rv_live && !redirect_valid;

        if (redirect_valid) begin
            pc_n          = redirect_pc & ~XLEN'(3);
            resp_pc_n     = redirect_pc & ~XLEN'(3);
            outstanding_n = '0;
            drop_cnt_n    = drop_cnt + DW'(outstanding) - DW'(rv_drop || rv_live);
        end else begin
            if (grant)   pc_n      = pc_q + XLEN'(4);
            if (rv_live) resp_pc_n = resp_pc + XLEN'(4);
            outstanding_n = outstanding + CW'(grant) - CW'(rv_live);
            drop_cnt_n    = drop_cnt - DW'(rv_drop);
        end
    end

    assign imem_addr = pc_q;
    assign id_pc     = fifo_head.pc;
    assign id_instr  = id_valid ? fifo_head.instr : NOP;

endmodule
